// File: rtl/ctrl_unit.sv
// ctrl_unit: single-cycle instruction decoder that turns Op/Func into datapath control flags and an ALU opcode.
// Optional macro CTRL_ILLEGAL_STICKY_EN adds a registered sticky IllegalSeen flag; otherwise IllegalSeen is tied to 0.
module ctrl_unit (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [5:0] Op,
   input  logic [5:0] Func,
   output logic       Branch,
   output logic       MtoR,
   output logic       MW,
   output logic       MR,
   output logic       Alusel,
   output logic       RW,
   output logic       J,
   output logic       Jal,
   output logic       Jr,
   output logic       LB,
   output logic       blez,
   output logic       rotrv,
   output logic       bltzal,
   output logic [3:0] ALUOp,
   output logic       Illegal,
   output logic       IllegalSeen
);

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BLTZAL = 6'b000001;

   localparam logic [5:0] FN_NOP    = 6'b000000;
   localparam logic [5:0] FN_ADDU   = 6'b100001;
   localparam logic [5:0] FN_SUBU   = 6'b100011;
   localparam logic [5:0] FN_ROTRV  = 6'b000110;
   localparam logic [5:0] FN_JR     = 6'b001000;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_OR    = 4'b0010;
   localparam logic [3:0] ALU_LUI   = 4'b0011;
   localparam logic [3:0] ALU_ROTR  = 4'b0100;

   // Every output defaults to 0 so unlisted and illegal encodings are inert.
   always_comb begin
      Branch  = 1'b0;
      MtoR    = 1'b0;
      MW      = 1'b0;
      MR      = 1'b0;
      Alusel  = 1'b0;
      RW      = 1'b0;
      J       = 1'b0;
      Jal     = 1'b0;
      Jr      = 1'b0;
      LB      = 1'b0;
      blez    = 1'b0;
      rotrv   = 1'b0;
      bltzal  = 1'b0;
      ALUOp   = ALU_ADD;
      Illegal = 1'b0;
      case (Op)
         OP_RTYPE: begin
            case (Func)
               FN_NOP: begin
                  Illegal = 1'b0;
               end
               FN_ADDU: begin
                  RW    = 1'b1;
                  ALUOp = ALU_ADD;
               end
               FN_SUBU: begin
                  RW    = 1'b1;
                  ALUOp = ALU_SUB;
               end
               FN_ROTRV: begin
                  rotrv = 1'b1;
                  RW    = 1'b1;
                  ALUOp = ALU_ROTR;
               end
               FN_JR: begin
                  Jr = 1'b1;
               end
               default: begin
                  Illegal = 1'b1;
               end
            endcase
         end
         OP_ORI: begin
            Alusel = 1'b1;
            RW     = 1'b1;
            ALUOp  = ALU_OR;
         end
         OP_LUI: begin
            Alusel = 1'b1;
            RW     = 1'b1;
            ALUOp  = ALU_LUI;
         end
         OP_LW: begin
            MR     = 1'b1;
            MtoR   = 1'b1;
            Alusel = 1'b1;
            RW     = 1'b1;
            ALUOp  = ALU_ADD;
         end
         OP_LB: begin
            MR     = 1'b1;
            MtoR   = 1'b1;
            Alusel = 1'b1;
            RW     = 1'b1;
            LB     = 1'b1;
            ALUOp  = ALU_ADD;
         end
         OP_SW: begin
            MW     = 1'b1;
            Alusel = 1'b1;
            ALUOp  = ALU_ADD;
         end
         OP_BEQ: begin
            Branch = 1'b1;
            ALUOp  = ALU_SUB;
         end
         OP_BLEZ: begin
            blez = 1'b1;
         end
         OP_J: begin
            J = 1'b1;
         end
         OP_JAL: begin
            Jal = 1'b1;
            RW  = 1'b1;
         end
         OP_BLTZAL: begin
            bltzal = 1'b1;
            RW     = 1'b1;
         end
         default: begin
            Illegal = 1'b1;
         end
      endcase
   end

`ifdef CTRL_ILLEGAL_STICKY_EN
   // Sticky flag: once any illegal encoding is decoded it stays set until RESET.
   logic illegal_seen_q = 1'b0;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         illegal_seen_q <= 1'b0;
      end else if (Illegal) begin
         illegal_seen_q <= 1'b1;
      end
   end

   assign IllegalSeen = illegal_seen_q;
`else
   logic unused_clk_rst;

   assign unused_clk_rst = CLK ^ RESET;
   assign IllegalSeen    = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: randomized + swept stimulus for ctrl_unit, checked by a scoreboard against a table-driven reference model.
// Honours CTRL_ILLEGAL_STICKY_EN the same way as the design.
module tb_ctrl_unit;

`ifdef CTRL_ILLEGAL_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif
   localparam int N_RAND = 400;

   // Control-flag masks, packed in the order {Branch,MtoR,MW,MR,Alusel,RW,J,Jal,Jr,LB,blez,rotrv,bltzal}.
   localparam logic [12:0] C_BR     = 13'h1000;
   localparam logic [12:0] C_MTOR   = 13'h0800;
   localparam logic [12:0] C_MW     = 13'h0400;
   localparam logic [12:0] C_MR     = 13'h0200;
   localparam logic [12:0] C_ALUS   = 13'h0100;
   localparam logic [12:0] C_RW     = 13'h0080;
   localparam logic [12:0] C_J      = 13'h0040;
   localparam logic [12:0] C_JAL    = 13'h0020;
   localparam logic [12:0] C_JR     = 13'h0010;
   localparam logic [12:0] C_LB     = 13'h0008;
   localparam logic [12:0] C_BLEZ   = 13'h0004;
   localparam logic [12:0] C_ROTRV  = 13'h0002;
   localparam logic [12:0] C_BLTZAL = 13'h0001;

   typedef struct {
      logic [5:0]  op;
      bit          any_func;
      logic [5:0]  func;
      logic [12:0] ctl;
      logic [3:0]  alu;
   } entry_t;

   typedef struct packed {
      logic [12:0] ctl;
      logic [3:0]  alu;
      logic        ill;
      logic        seen;
   } exp_t;

   entry_t tbl[$];
   exp_t   sb[$];

   logic       clk = 1'b0;
   logic       RESET;
   logic [5:0] Op;
   logic [5:0] Func;
   logic       Branch, MtoR, MW, MR, Alusel, RW;
   logic       J, Jal, Jr, LB, blez, rotrv, bltzal;
   logic [3:0] ALUOp;
   logic       Illegal, IllegalSeen;

   int   checks = 0;
   int   errors = 0;
   logic seen_m = 1'b0;

   always #5 clk = ~clk;

   ctrl_unit dut (
      .CLK(clk),
      .RESET(RESET),
      .Op(Op),
      .Func(Func),
      .Branch(Branch),
      .MtoR(MtoR),
      .MW(MW),
      .MR(MR),
      .Alusel(Alusel),
      .RW(RW),
      .J(J),
      .Jal(Jal),
      .Jr(Jr),
      .LB(LB),
      .blez(blez),
      .rotrv(rotrv),
      .bltzal(bltzal),
      .ALUOp(ALUOp),
      .Illegal(Illegal),
      .IllegalSeen(IllegalSeen)
   );

   task automatic add(input logic [5:0] op, input bit any_func, input logic [5:0] func,
                      input logic [12:0] ctl, input logic [3:0] alu);
      entry_t e;
      e.op = op; e.any_func = any_func; e.func = func; e.ctl = ctl; e.alu = alu;
      tbl.push_back(e);
   endtask

   // Reference: look the instruction up in the table; anything not found is illegal with all controls 0.
   function automatic exp_t model(input logic [5:0] op, input logic [5:0] func);
      exp_t e;
      e = '0;
      e.ill = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].op == op && (tbl[i].any_func || tbl[i].func == func)) begin
            e.ctl = tbl[i].ctl;
            e.alu = tbl[i].alu;
            e.ill = 1'b0;
         end
      end
      return e;
   endfunction

   // Inputs change just after the rising edge; the sticky model tracks the register value after each edge.
   task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] func);
      exp_t e;
      @(posedge clk);
      #1;
      RESET = rst;
      Op    = op;
      Func  = func;
      e      = model(op, func);
      e.seen = seen_m;
      sb.push_back(e);
      if (STICKY) seen_m = rst ? 1'b0 : (seen_m | e.ill);
   endtask

   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = {Branch, MtoR, MW, MR, Alusel, RW, J, Jal, Jr, LB, blez, rotrv, bltzal,
              ALUOp, Illegal, IllegalSeen};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL decode op=%b func=%b rst=%b got %h want %h", Op, Func, RESET, a, e);
         end
         checks++;
         if ($countones({J, Jal, Jr, Branch, blez, bltzal, rotrv}) > 1) begin
            errors++;
            $display("FAIL onehot op=%b func=%b got %b want at most one set", Op, Func,
                     {J, Jal, Jr, Branch, blez, bltzal, rotrv});
         end
         checks++;
         if ((MtoR && !(MR && RW)) || (MW && RW)) begin
            errors++;
            $display("FAIL implication op=%b func=%b got MtoR=%b MR=%b RW=%b MW=%b want consistent",
                     Op, Func, MtoR, MR, RW, MW);
         end
      end
   end

   initial begin
      logic [5:0] rop;
      RESET = 1'b1;
      Op    = 6'b000000;
      Func  = 6'b000000;

      add(6'b000000, 1'b0, 6'b000000, 13'h0, 4'b0000);
      add(6'b000000, 1'b0, 6'b100001, C_RW, 4'b0000);
      add(6'b000000, 1'b0, 6'b100011, C_RW, 4'b0001);
      add(6'b000000, 1'b0, 6'b000110, C_ROTRV | C_RW, 4'b0100);
      add(6'b000000, 1'b0, 6'b001000, C_JR, 4'b0000);
      add(6'b001101, 1'b1, 6'b0, C_ALUS | C_RW, 4'b0010);
      add(6'b001111, 1'b1, 6'b0, C_ALUS | C_RW, 4'b0011);
      add(6'b100011, 1'b1, 6'b0, C_MR | C_MTOR | C_ALUS | C_RW, 4'b0000);
      add(6'b100000, 1'b1, 6'b0, C_MR | C_MTOR | C_ALUS | C_RW | C_LB, 4'b0000);
      add(6'b101011, 1'b1, 6'b0, C_MW | C_ALUS, 4'b0000);
      add(6'b000100, 1'b1, 6'b0, C_BR, 4'b0001);
      add(6'b000110, 1'b1, 6'b0, C_BLEZ, 4'b0000);
      add(6'b000010, 1'b1, 6'b0, C_J, 4'b0000);
      add(6'b000011, 1'b1, 6'b0, C_JAL | C_RW, 4'b0000);
      add(6'b000001, 1'b1, 6'b0, C_BLTZAL | C_RW, 4'b0000);

      // Reset wins over a simultaneous illegal instruction.
      drive(1'b1, 6'b111111, 6'b000000);
      drive(1'b0, 6'b000000, 6'b000000);
      drive(1'b0, 6'b100011, 6'($urandom));
      drive(1'b0, 6'b000000, 6'b000110);
      drive(1'b0, 6'b000000, 6'b001000);
      for (int i = 0; i < tbl.size(); i++) begin
         drive(1'b0, tbl[i].op, tbl[i].any_func ? 6'($urandom) : tbl[i].func);
      end

      // Sticky sequence: one illegal cycle, several beq cycles, then a single reset edge.
      drive(1'b0, 6'b111111, 6'b000000);
      repeat (3) drive(1'b0, 6'b000100, 6'($urandom));
      drive(1'b1, 6'b000100, 6'b000000);
      drive(1'b0, 6'b000100, 6'b000000);
      drive(1'b0, 6'b000000, 6'b000000);

      for (int op = 0; op < 64; op++) begin
         for (int fn = 0; fn < 64; fn++) begin
            drive(($urandom_range(0, 31) == 0), 6'(op), 6'(fn));
         end
      end

      for (int n = 0; n < N_RAND; n++) begin
         if ($urandom_range(0, 1) == 1) rop = tbl[$urandom_range(0, tbl.size() - 1)].op;
         else rop = 6'($urandom);
         drive(($urandom_range(0, 15) == 0), rop, 6'($urandom));
      end

      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 No parameters.
REQ-002 CLK  in  1  clock, rising edge; only IllegalSeen uses it.
REQ-003 RESET  in  1  reset, synchronous, active-high.
REQ-004 Op  in  6  instruction bits [31:26].
REQ-005 Func  in  6  instruction bits [5:0]; decoded only when Op=000000.
REQ-006 Branch, MtoR, MW, MR, Alusel, RW  out  1 each
- Branch: beq.
- MtoR: writeback from memory.
- MW: memory write.
- MR: memory read.
- Alusel: ALU B operand is the immediate.
- RW: register write.
REQ-007 J, Jal, Jr, LB, blez, rotrv, bltzal  out  1 each; one-hot instruction flags; LB is the byte-load flag.
REQ-008 ALUOp  out  4  ALU operation:
- 0000 ADD, 0001 SUB, 0010 OR, 0011 LUI (B<<16), 0100 ROTR (rotate B right by A[4:0]).
- All other codes are reserved and never driven.
REQ-009 Illegal  out  1  combinational: Op/Func not in the decode table.
REQ-010 IllegalSeen  out  1  registered sticky illegal flag (see Configuration).

Function
REQ-011 All outputs except IllegalSeen SHALL be purely combinational from Op/Func, with zero-cycle latency.
REQ-012 Decode table (unlisted outputs = 0):
- addu (Op 000000, Func 100001): RW, ALUOp 0000.
- subu (Op 000000, Func 100011): RW, ALUOp 0001.
- rotrv (Op 000000, Func 000110): rotrv, RW, ALUOp 0100.
- jr (Op 000000, Func 001000): Jr.
- ori (Op 001101): Alusel, RW, ALUOp 0010.
- lui (Op 001111): Alusel, RW, ALUOp 0011.
- lw (Op 100011): MR, MtoR, Alusel, RW, ALUOp 0000.
- lb (Op 100000): MR, MtoR, Alusel, RW, LB, ALUOp 0000.
- sw (Op 101011): MW, Alusel, ALUOp 0000.
- beq (Op 000100): Branch, ALUOp 0001.
- blez (Op 000110): blez.
- j (Op 000010): J.
- jal (Op 000011): Jal, RW.
- bltzal (Op 000001): bltzal, RW.
REQ-013 Op=000000 with Func=000000 (nop/sll, including all-zero flushed instructions) SHALL drive every output to 0, with Illegal=0.
REQ-014 Any other Op, or Op=000000 with an unlisted Func, SHALL drive every control output and ALUOp to 0, with Illegal=1.
REQ-015 At most one of J, Jal, Jr, Branch, blez, bltzal, rotrv SHALL be 1 at any time.
REQ-016 MtoR=1 SHALL imply MR=1 and RW=1; MW=1 SHALL imply RW=0.
REQ-017 The decode SHALL contain no latches; all outputs are fully assigned on every path.

Reset
REQ-018 RESET=1 at a CLK rising edge SHALL clear IllegalSeen to 0; this reset has priority over a simultaneous Illegal=1.
REQ-019 RESET SHALL NOT affect any combinational output.

Configuration
REQ-020 Macro CTRL_ILLEGAL_STICKY_EN, when defined:
- On each CLK rising edge with RESET=0, IllegalSeen <= IllegalSeen | Illegal.
- IllegalSeen powers up at 0.
REQ-021 When CTRL_ILLEGAL_STICKY_EN is undefined:
- IllegalSeen is tied to 0.
- CLK and RESET are unused.
- All other behaviour is identical.

Verification
REQ-022 Op=100011, Func=xx -> MR=MtoR=Alusel=RW=1, ALUOp=0000, every other output 0.
REQ-023 Op=000000, Func=000110 -> rotrv=RW=1, ALUOp=0100; Op=000000, Func=001000 -> Jr=1, RW=0.
REQ-024 Op=000000, Func=000000 -> all outputs 0, Illegal=0; Op=111111 -> all controls 0, Illegal=1.
REQ-025 Macro defined: Op=111111 for 1 cycle, then Op=000100 -> IllegalSeen=1 after the edge and it stays 1 (Branch=1, ALUOp=0001 meanwhile); RESET=1 for 1 edge -> IllegalSeen=0.
REQ-026 Macro defined: RESET=1 and Op=111111 at the same edge -> IllegalSeen=0.
REQ-027 Sweep all 64 Op values x all Func values -> one-hot rule (REQ-015) and implications (REQ-016) hold, and Illegal=1 exactly for entries outside the table.
